// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32I funct3 codes, sequencer states, misalignment test.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LD2  = 2'd1,
      ST   = 2'd2
   } lsu_state_t;

   // Halfwords need an even address, words a multiple of four; bytes are always aligned.
   function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
      return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
             ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_load_merge.sv
// Merges two aligned words into one misaligned load result and extends it per funct3.
// Latency: purely combinational.
// Backpressure: none.
module lsu_load_merge
   import lsu_pkg::*;
(
   input  logic [31:0] lo,
   input  logic [23:0] hi,       // low 3 bytes of the upper word; byte 3 can never reach the result
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   // Select the 32-bit window starting at the byte offset, then sign/zero extend.
   always_comb begin
      shifted = lo;
      case (offset)
         2'd0:    shifted = lo;
         2'd1:    shifted = {hi[7:0],  lo[31:8]};
         2'd2:    shifted = {hi[15:0], lo[31:16]};
         default: shifted = {hi[23:0], lo[31:24]};
      endcase

      rdata = shifted;
      case (funct3)
         F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  rdata = {24'b0, shifted[7:0]};
         F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  rdata = {16'b0, shifted[15:0]};
         default: rdata = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_misalign.sv
// Load/store sequencer: aligned accesses pass through; misaligned loads become two word reads, stores become byte writes.
// Latency: aligned 0 extra cycles; misaligned load 1 extra cycle; misaligned SH/SW 1/3 extra cycles.
// Backpressure: stall holds the core (which keeps req_* stable) while a split access is in progress.
module lsu_misalign
   import lsu_pkg::*;
#(
   parameter int SPLIT_EN = 1,
   parameter int CNT_W    = 32
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [2:0]       req_funct3,
   output logic             stall,
   output logic [31:0]      rdata,
   output logic             misalign_evt,
   output logic [CNT_W-1:0] misalign_cnt,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   output logic [2:0]       mem_funct3,
   input  logic [31:0]      mem_rd
);

   lsu_state_t  state, state_nxt;
   logic [1:0]  k_q, k_nxt;
   logic [31:0] lo_q;
   logic        mis, accept, split, last_byte;
   logic [1:0]  byte_idx;
   logic [7:0]  wbyte;
   logic [31:0] aligned_a;
   logic [31:0] merged;

   assign mis       = is_misaligned(req_funct3, req_addr[1:0]);
   assign accept    = (state == IDLE) && req_valid && mis && !reset;
   assign split     = (SPLIT_EN != 0) && accept;
   assign aligned_a = {req_addr[31:2], 2'b00};
   // SH writes bytes 0..1, SW writes bytes 0..3.
   assign last_byte = (k_q == ((req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3));
   // Byte 0 goes out from IDLE; later bytes come from the ST state's counter.
   assign byte_idx  = (state == ST) ? k_q : 2'd0;

   lsu_load_merge u_merge (
      .lo     (lo_q),
      .hi     (mem_rd[23:0]),
      .offset (req_addr[1:0]),
      .funct3 (req_funct3),
      .rdata  (merged)
   );

   // State, byte counter and first-word capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         k_q   <= 2'd0;
         lo_q  <= 32'd0;
      end else begin
         state <= state_nxt;
         k_q   <= k_nxt;
         if (split && !req_we)
            lo_q <= mem_rd;
      end
   end

   // Saturating count of accepted misaligned accesses, counted even when not split.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         misalign_cnt <= '0;
      else if (accept && (misalign_cnt != {CNT_W{1'b1}}))
         misalign_cnt <= misalign_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Next state: a dropped req_valid aborts any split back to IDLE.
   always_comb begin
      state_nxt = state;
      k_nxt     = k_q;
      case (state)
         IDLE: begin
            if (split) begin
               if (req_we) begin
                  state_nxt = ST;
                  k_nxt     = 2'd1;
               end else begin
                  state_nxt = LD2;
               end
            end
         end
         LD2: state_nxt = IDLE;
         ST: begin
            if (!req_valid || last_byte) begin
               state_nxt = IDLE;
               k_nxt     = 2'd0;
            end else begin
               k_nxt = k_q + 2'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            k_nxt     = 2'd0;
         end
      endcase
   end

   // Store byte for the current split write.
   always_comb begin
      wbyte = req_wdata[7:0];
      case (byte_idx)
         2'd0:    wbyte = req_wdata[7:0];
         2'd1:    wbyte = req_wdata[15:8];
         2'd2:    wbyte = req_wdata[23:16];
         default: wbyte = req_wdata[31:24];
      endcase
   end

   // Memory-side outputs: pass-through unless a split access owns the bus.
   always_comb begin
      mem_we       = req_valid & req_we;
      mem_a        = req_addr;
      mem_wd       = req_wdata;
      mem_funct3   = req_funct3;
      stall        = 1'b0;
      rdata        = mem_rd;
      misalign_evt = accept;
      case (state)
         IDLE: begin
            if (split && !req_we) begin
               mem_we     = 1'b0;
               mem_a      = aligned_a;
               mem_funct3 = F3_LW;
               stall      = 1'b1;
            end else if (split) begin
               mem_we     = 1'b1;
               mem_a      = req_addr;
               mem_wd     = {24'b0, wbyte};
               mem_funct3 = F3_SB;
               stall      = 1'b1;
            end
         end
         LD2: begin
            mem_we     = 1'b0;
            mem_a      = aligned_a + 32'd4;
            mem_funct3 = F3_LW;
            rdata      = merged;
         end
         ST: begin
            if (req_valid) begin
               mem_we     = 1'b1;
               mem_a      = req_addr + {30'b0, k_q};
               mem_wd     = {24'b0, wbyte};
               mem_funct3 = F3_SB;
               stall      = !last_byte;
            end else begin
               mem_we = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule
